// File: rtl/uart_tx_frame_ctrl.sv
// ============================================================================
// uart_tx_frame_ctrl
// ----------------------------------------------------------------------------
// UART transmit framing controller and serializer. One bit is sent per i_clk
// cycle: start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit
// taken from the upstream parity stage, then a stop bit (1).
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_Data_Valid  send request, honoured only in IDLE
//   i_P_DATA      parallel data, latched on accept
//   i_PAR_EN      parity enable, latched on accept
//   i_par_bit     parity bit from the parity stage, sampled in PARITY
//   o_TX_OUT      serial line, idle high
//   o_busy        high while a frame is on the line
//   o_done        one-cycle pulse during the stop bit
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line high, waiting for i_Data_Valid
// START  | drive start bit (0), clear bit counter
// DATA   | drive data[bit_cnt], LSB first, DATA_WIDTH cycles
// PARITY | drive i_par_bit (only when latched PAR_EN = 1)
// STOP   | drive stop bit (1), pulse o_done
//
// Outputs are registered from the current state, so the line lags the state
// register by one cycle. IDLE is re-entered while the stop bit is still on
// the line; a request sampled on the edge where o_busy falls is therefore
// accepted and the next start bit follows a single idle cycle.
// ============================================================================
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_Data_Valid,
    input  logic [DATA_WIDTH-1:0] i_P_DATA,
    input  logic                  i_PAR_EN,
    input  logic                  i_par_bit,
    output logic                  o_TX_OUT,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic [CNT_W-1:0]      bit_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            data_q   <= '0;
            par_en_q <= 1'b0;
            bit_cnt  <= '0;
            o_TX_OUT <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_TX_OUT <= 1'b1;
                    o_busy   <= 1'b0;
                    o_done   <= 1'b0;
                    if (i_Data_Valid) begin
                        data_q   <= i_P_DATA;
                        par_en_q <= i_PAR_EN;
                        state    <= START;
                    end
                end
                START: begin
                    o_TX_OUT <= 1'b0;
                    o_busy   <= 1'b1;
                    o_done   <= 1'b0;
                    bit_cnt  <= '0;
                    state    <= DATA;
                end
                DATA: begin
                    o_TX_OUT <= data_q[bit_cnt];
                    o_busy   <= 1'b1;
                    o_done   <= 1'b0;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        state   <= par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    // parity stage output has been stable since accept
                    o_TX_OUT <= i_par_bit;
                    o_busy   <= 1'b1;
                    o_done   <= 1'b0;
                    state    <= STOP;
                end
                STOP: begin
                    o_TX_OUT <= 1'b1;
                    o_busy   <= 1'b1;
                    o_done   <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    o_TX_OUT <= 1'b1;
                    o_busy   <= 1'b0;
                    o_done   <= 1'b0;
                    bit_cnt  <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
